// File: rtl/modulo_pkg.sv
// modulo_pkg: FSM state and operation mode encodings shared by the modulo divider
package modulo_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;
    localparam logic [1:0] MODE_UMOD = 2'b00;
    localparam logic [1:0] MODE_UDIV = 2'b01;
    localparam logic [1:0] MODE_SMOD = 2'b10;
    localparam logic [1:0] MODE_SDIV = 2'b11;
endpackage

// File: rtl/modulo_sub_stage.sv
// modulo_sub_stage: one restoring shift-subtract step on WIDTH+1 bits
module modulo_sub_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    assign sh    = {rem_i, bit_i};
    // rem_i < dvs_i keeps the difference within +/-2^WIDTH, so the top bit is a valid borrow
    assign diff  = sh - {1'b0, dvs_i};
    assign q_o   = !diff[WIDTH];
    assign rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/modulo_divider.sv
// modulo_divider: multi-cycle signed/unsigned divide and modulo with registered outputs
module modulo_divider
    import modulo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] zahl1_i,
    input  logic [WIDTH-1:0] zahl2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(WIDTH);
    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] a_q, b_q, quo_q, dvs_q, rem_q, res_q;
    logic [WIDTH-1:0] rem_n, res_fix;
    logic [CW-1:0]    cnt_q;
    logic             neg_a_q, neg_b_q, ready_q, valid_q, dz_q;
    logic             accept, is_div, sgn, q_bit, ready_d, valid_d;
    assign accept  = start_i && ready_q;
    assign is_div  = (mode_q == MODE_UDIV) || (mode_q == MODE_SDIV);
    assign sgn     = (SIGNED_EN != 0) && ((mode_q == MODE_SMOD) || (mode_q == MODE_SDIV));
    assign res_fix = is_div ? ((neg_a_q ^ neg_b_q) ? -quo_q : quo_q) : (neg_a_q ? -rem_q : rem_q);
    modulo_sub_stage #(.WIDTH(WIDTH)) u_stage (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (rem_n),
        .q_o   (q_bit)
    );
    always_ff @(posedge clk) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? LOAD : state_q;
            LOAD:       state_d = (b_q == '0) ? DONE : CALC;
            CALC:       state_d = (cnt_q == '0) ? FIX : CALC;
            FIX:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end
    // Flags trail the state by one cycle so a result is always shown before a held start can replace it
    always_comb begin
        ready_d = !accept && ((state_q == IDLE) || (state_q == DONE));
        valid_d = !accept && (state_q == DONE);
    end
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            mode_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            if (accept) begin
                mode_q <= mode_i;
                a_q    <= zahl1_i;
                b_q    <= zahl2_i;
                dz_q   <= 1'b0;
            end
            if (state_q == LOAD) begin
                neg_a_q <= sgn && a_q[WIDTH-1];
                neg_b_q <= sgn && b_q[WIDTH-1];
                quo_q   <= (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
                dvs_q   <= (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
                rem_q   <= '0;
                cnt_q   <= CW'(WIDTH - 1);
                if (b_q == '0) begin
                    res_q <= is_div ? '1 : a_q;
                    dz_q  <= 1'b1;
                end
            end
            if (state_q == CALC) begin
                rem_q <= rem_n;
                quo_q <= {quo_q[WIDTH-2:0], q_bit};
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == FIX) res_q <= res_fix;
        end
    end
    assign ready_o    = ready_q;
    assign valid_o    = valid_q;
    assign ergebnis_o = res_q;
    assign div_zero_o = dz_q;
endmodule

// File: tb/tb_modulo_divider.sv
// tb_modulo_divider: directed self-checking bench for modulo_divider with WIDTH=16
module tb_modulo_divider;
    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [15:0] zahl1_i;
    logic [15:0] zahl2_i;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] ergebnis_o;
    logic        div_zero_o;
    int checks;
    int errors;
    modulo_divider #(.WIDTH(16), .SIGNED_EN(1)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
        .zahl1_i    (zahl1_i),
        .zahl2_i    (zahl2_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ergebnis_o (ergebnis_o),
        .div_zero_o (div_zero_o)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic wait_valid(inout int lat);
        while (!valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        mode_i = m; zahl1_i = a; zahl2_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        wait_valid(lat);
    endtask
    task automatic test_reset;
        rst_i = 1'b0; start_i = 1'b1; mode_i = 2'b01; zahl1_i = 16'h0011; zahl2_i = 16'h0005;
        repeat (2) @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (ergebnis_o !== 16'h0000) begin errors++; $display("FAIL reset_ergebnis got=%h exp=0000", ergebnis_o); end
        checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b exp=0", div_zero_o); end
        rst_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_dominates_start ready got=%b exp=1", ready_o); end
    endtask
    task automatic test_modes;
        logic [49:0] v [16];
        int lat;
        v = '{
            {2'b00, 16'h0011, 16'h0005, 16'h0002}, {2'b01, 16'h0011, 16'h0005, 16'h0003},
            {2'b11, 16'hFFEF, 16'h0005, 16'hFFFD}, {2'b10, 16'hFFEF, 16'h0005, 16'hFFFE},
            {2'b11, 16'h8000, 16'hFFFF, 16'h8000}, {2'b10, 16'h8000, 16'hFFFF, 16'h0000},
            {2'b00, 16'hFFFF, 16'h0010, 16'h000F}, {2'b01, 16'hFFFF, 16'h0010, 16'h0FFF},
            {2'b11, 16'h0011, 16'hFFFB, 16'hFFFD}, {2'b10, 16'h0011, 16'hFFFB, 16'h0002},
            {2'b11, 16'hFFEF, 16'hFFFB, 16'h0003}, {2'b10, 16'hFFEF, 16'hFFFB, 16'hFFFE},
            {2'b01, 16'h0005, 16'h0011, 16'h0000}, {2'b01, 16'hFFFF, 16'h0001, 16'hFFFF},
            {2'b11, 16'h8000, 16'h0002, 16'hC000}, {2'b01, 16'h8000, 16'hFFFF, 16'h0000}
        };
        for (int i = 0; i < 16; i++) begin
            run_op(v[i][49:48], v[i][47:32], v[i][31:16], lat);
            checks++; if (lat != 19) begin errors++; $display("FAIL mode_latency[%0d] got=%0d exp=19", i, lat); end
            checks++; if (ergebnis_o !== v[i][15:0]) begin errors++; $display("FAIL mode_result[%0d] got=%h exp=%h", i, ergebnis_o, v[i][15:0]); end
            checks++; if (div_zero_o !== 1'b0) begin errors++; $display("FAIL mode_div_zero[%0d] got=%b exp=0", i, div_zero_o); end
        end
    endtask
    task automatic test_div_zero;
        logic [49:0] v [4];
        int lat;
        v = '{
            {2'b01, 16'h0007, 16'h0000, 16'hFFFF}, {2'b00, 16'h0007, 16'h0000, 16'h0007},
            {2'b11, 16'hFFF9, 16'h0000, 16'hFFFF}, {2'b10, 16'hFFF9, 16'h0000, 16'hFFF9}
        };
        for (int i = 0; i < 4; i++) begin
            run_op(v[i][49:48], v[i][47:32], v[i][31:16], lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL dz_latency[%0d] got=%0d exp=2", i, lat); end
            checks++; if (ergebnis_o !== v[i][15:0]) begin errors++; $display("FAIL dz_result[%0d] got=%h exp=%h", i, ergebnis_o, v[i][15:0]); end
            checks++; if (div_zero_o !== 1'b1) begin errors++; $display("FAIL dz_flag[%0d] got=%b exp=1", i, div_zero_o); end
        end
    endtask
    task automatic test_ignore_busy;
        int lat;
        @(negedge clk);
        mode_i = 2'b00; zahl1_i = 16'h0011; zahl2_i = 16'h0005; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        repeat (4) begin @(negedge clk); lat++; end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready_o); end
        mode_i = 2'b01; zahl1_i = 16'h0064; zahl2_i = 16'h0003; start_i = 1'b1;
        @(negedge clk);
        lat++;
        start_i = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL busy_latency got=%0d exp=19", lat); end
        checks++; if (ergebnis_o !== 16'h0002) begin errors++; $display("FAIL busy_result got=%h exp=0002", ergebnis_o); end
        repeat (3) @(negedge clk);
        checks++; if (ergebnis_o !== 16'h0002 || valid_o !== 1'b1) begin errors++; $display("FAIL busy_hold got=%h/%b exp=0002/1", ergebnis_o, valid_o); end
    endtask
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        mode_i = 2'b01; zahl1_i = 16'h0064; zahl2_i = 16'h0007; start_i = 1'b1;
        @(negedge clk);
        lat = 0;
        wait_valid(lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=19", lat); end
        checks++; if (ergebnis_o !== 16'h000E) begin errors++; $display("FAIL b2b_first_result got=%h exp=000E", ergebnis_o); end
        mode_i = 2'b00;
        @(negedge clk);
        start_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", valid_o); end
        lat = 0;
        wait_valid(lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=19", lat); end
        checks++; if (ergebnis_o !== 16'h0002) begin errors++; $display("FAIL b2b_second_result got=%h exp=0002", ergebnis_o); end
    endtask
    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        mode_i = 2'b01; zahl1_i = 16'h1234; zahl2_i = 16'h0003; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", valid_o); end
        checks++; if (ergebnis_o !== 16'h0000) begin errors++; $display("FAIL midrst_ergebnis got=%h exp=0000", ergebnis_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
        rst_i = 1'b1;
        repeat (25) @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_result got=%b exp=0", valid_o); end
        run_op(2'b01, 16'h0011, 16'h0005, lat);
        checks++; if (lat != 19) begin errors++; $display("FAIL midrst_latency got=%0d exp=19", lat); end
        checks++; if (ergebnis_o !== 16'h0003) begin errors++; $display("FAIL midrst_result got=%h exp=0003", ergebnis_o); end
    endtask
    initial begin
        checks = 0; errors = 0;
        rst_i = 1'b0; start_i = 1'b0; mode_i = 2'b00; zahl1_i = '0; zahl2_i = '0;
        test_reset;
        test_modes;
        test_div_zero;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
